// File: rtl/tribuffer_axil_pkg.sv
// Shared register map, response codes, channel state types and the
// byte-strobe merge helper for the tribuffer AXI4-Lite register bank.
package tribuffer_axil_pkg;

  localparam logic [2:0] REG_CTRL0  = 3'd0;
  localparam logic [2:0] REG_CTRL1  = 3'd1;
  localparam logic [2:0] REG_CTRL2  = 3'd2;
  localparam logic [2:0] REG_CTRL3  = 3'd3;
  localparam logic [2:0] REG_STATUS = 3'd4;
  localparam logic [2:0] REG_EVENT  = 3'd5;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_RESP} r_state_t;

  function automatic logic [31:0] apply_wstrb(input logic [31:0] old,
                                              input logic [31:0] data,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old;
    for (int unsigned b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = data[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/tribuffer_axil_slave.sv
// AXI4-Lite responder for the tribuffer IP: four RW control words, a live
// status word and a sticky W1C event word, with decoupled AW/W/B/AR/R channels.
module tribuffer_axil_slave
  import tribuffer_axil_pkg::*;
#(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 5,
  parameter logic [31:0] C_CTRL_RESET       = 32'h0000_0000
) (
  input  logic                                s00_axi_aclk,
  input  logic                                s00_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]       s00_axi_awaddr,
  input  logic [2:0]                          s00_axi_awprot,
  input  logic                                s00_axi_awvalid,
  output logic                                s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]       s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]     s00_axi_wstrb,
  input  logic                                s00_axi_wvalid,
  output logic                                s00_axi_wready,
  output logic [1:0]                          s00_axi_bresp,
  output logic                                s00_axi_bvalid,
  input  logic                                s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]       s00_axi_araddr,
  input  logic [2:0]                          s00_axi_arprot,
  input  logic                                s00_axi_arvalid,
  output logic                                s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]       s00_axi_rdata,
  output logic [1:0]                          s00_axi_rresp,
  output logic                                s00_axi_rvalid,
  input  logic                                s00_axi_rready,
  output logic [3:0][C_S_AXI_DATA_WIDTH-1:0]  ctrl_o,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]       status_i,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]       event_i
);

  w_state_t         w_state, w_next;
  r_state_t         r_state, r_next;
  logic [2:0]       awaddr_q;
  logic [31:0]      wdata_q;
  logic [3:0]       wstrb_q;
  logic [3:0][31:0] ctrl_q;
  logic [31:0]      sticky_q;
  logic             aw_hs, w_hs, ar_hs, commit;
  logic [2:0]       wr_idx, rd_idx;
  logic [31:0]      wr_data, clr_mask, rd_data_c;
  logic [3:0]       wr_strb;
  logic [1:0]       rd_resp_c;
  logic             unused_bits;

  assign unused_bits = ^{s00_axi_awprot, s00_axi_arprot,
                         s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  assign s00_axi_awready = (w_state == W_IDLE) || (w_state == W_HAVE_D);
  assign s00_axi_wready  = (w_state == W_IDLE) || (w_state == W_HAVE_A);
  assign s00_axi_bvalid  = (w_state == W_RESP);
  assign s00_axi_arready = (r_state == R_IDLE);
  assign s00_axi_rvalid  = (r_state == R_RESP);
  assign ctrl_o          = ctrl_q;

  assign aw_hs = s00_axi_awvalid && s00_axi_awready;
  assign w_hs  = s00_axi_wvalid  && s00_axi_wready;
  assign ar_hs = s00_axi_arvalid && s00_axi_arready;

  // Commit uses whichever half is still live on the bus, the other from the latch.
  assign wr_idx  = (w_state == W_HAVE_A) ? awaddr_q : s00_axi_awaddr[4:2];
  assign wr_data = (w_state == W_HAVE_D) ? wdata_q  : s00_axi_wdata;
  assign wr_strb = (w_state == W_HAVE_D) ? wstrb_q  : s00_axi_wstrb;

  always_comb begin
    w_next = w_state;
    commit = 1'b0;
    unique case (w_state)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          commit = 1'b1;
          w_next = W_RESP;
        end else if (aw_hs) begin
          w_next = W_HAVE_A;
        end else if (w_hs) begin
          w_next = W_HAVE_D;
        end
      end
      W_HAVE_A: if (w_hs) begin
        commit = 1'b1;
        w_next = W_RESP;
      end
      W_HAVE_D: if (aw_hs) begin
        commit = 1'b1;
        w_next = W_RESP;
      end
      W_RESP:   if (s00_axi_bready) w_next = W_IDLE;
      default:  w_next = W_IDLE;
    endcase
  end

  always_comb begin
    clr_mask = '0;
    if (commit && wr_idx == REG_EVENT) clr_mask = apply_wstrb('0, wr_data, wr_strb);
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      w_state       <= W_IDLE;
      awaddr_q      <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      ctrl_q        <= {4{C_CTRL_RESET}};
      sticky_q      <= '0;
      s00_axi_bresp <= RESP_OKAY;
    end else begin
      w_state  <= w_next;
      sticky_q <= (sticky_q & ~clr_mask) | event_i;
      if (aw_hs) awaddr_q <= s00_axi_awaddr[4:2];
      if (w_hs) begin
        wdata_q <= s00_axi_wdata;
        wstrb_q <= s00_axi_wstrb;
      end
      if (commit) begin
        if (!wr_idx[2]) ctrl_q[wr_idx[1:0]] <= apply_wstrb(ctrl_q[wr_idx[1:0]], wr_data, wr_strb);
        s00_axi_bresp <= (wr_idx > REG_EVENT) ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  assign rd_idx = s00_axi_araddr[4:2];

  always_comb begin
    rd_data_c = '0;
    rd_resp_c = RESP_OKAY;
    if (!rd_idx[2])                rd_data_c = ctrl_q[rd_idx[1:0]];
    else if (rd_idx == REG_STATUS) rd_data_c = status_i;
    else if (rd_idx == REG_EVENT)  rd_data_c = sticky_q;
    else                           rd_resp_c = RESP_SLVERR;
  end

  always_comb begin
    r_next = r_state;
    unique case (r_state)
      R_IDLE:  if (s00_axi_arvalid) r_next = R_RESP;
      R_RESP:  if (s00_axi_rready)  r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_state       <= R_IDLE;
      s00_axi_rdata <= '0;
      s00_axi_rresp <= RESP_OKAY;
    end else begin
      r_state <= r_next;
      if (ar_hs) begin
        s00_axi_rdata <= rd_data_c;
        s00_axi_rresp <= rd_resp_c;
      end
    end
  end

endmodule

// File: tb/tb_tribuffer_axil_slave.sv
// Directed bench for tribuffer_axil_slave: vector table of single transactions
// plus hand-written sequences for channel ordering, back-pressure, W1C and reset.
module tb_tribuffer_axil_slave;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [4:0]        awaddr, araddr;
  logic [2:0]        awprot, arprot;
  logic              awvalid, awready, wvalid, wready, bvalid, bready;
  logic              arvalid, arready, rvalid, rready;
  logic [31:0]       wdata, rdata, status_i, event_i;
  logic [3:0]        wstrb;
  logic [1:0]        bresp, rresp;
  logic [3:0][31:0]  ctrl_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  tribuffer_axil_slave #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(5),
    .C_CTRL_RESET(32'h0000_0000)
  ) dut (
    .s00_axi_aclk(clk),       .s00_axi_aresetn(rst_n),
    .s00_axi_awaddr(awaddr),  .s00_axi_awprot(awprot),
    .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
    .s00_axi_wdata(wdata),    .s00_axi_wstrb(wstrb),
    .s00_axi_wvalid(wvalid),  .s00_axi_wready(wready),
    .s00_axi_bresp(bresp),    .s00_axi_bvalid(bvalid),
    .s00_axi_bready(bready),
    .s00_axi_araddr(araddr),  .s00_axi_arprot(arprot),
    .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata),    .s00_axi_rresp(rresp),
    .s00_axi_rvalid(rvalid),  .s00_axi_rready(rready),
    .ctrl_o(ctrl_o),          .status_i(status_i),
    .event_i(event_i)
  );

  typedef struct {
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [1:0] resp);
    logic aw_done, w_done, aw_take, w_take;
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    aw_done = 1'b0; w_done = 1'b0;
    for (int n = 0; n < 20 && !(aw_done && w_done); n++) begin
      aw_take = awvalid && awready;
      w_take  = wvalid && wready;
      @(negedge clk);
      if (aw_take) begin awvalid = 1'b0; aw_done = 1'b1; end
      if (w_take)  begin wvalid  = 1'b0; w_done  = 1'b1; end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    chk("aw_w_accept", {aw_done, w_done}, 2'b11);
    for (int n = 0; n < 20 && !bvalid; n++) @(negedge clk);
    chk("bvalid_wait", bvalid, 1'b1);
    resp = bresp;
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] resp);
    logic ar_done, ar_take;
    @(negedge clk);
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    ar_done = 1'b0;
    for (int n = 0; n < 20 && !ar_done; n++) begin
      ar_take = arvalid && arready;
      @(negedge clk);
      if (ar_take) begin arvalid = 1'b0; ar_done = 1'b1; end
    end
    arvalid = 1'b0;
    chk("ar_accept", ar_done, 1'b1);
    for (int n = 0; n < 20 && !rvalid; n++) @(negedge clk);
    chk("rvalid_wait", rvalid, 1'b1);
    d = rdata;
    resp = rresp;
    @(negedge clk);
    rready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  r;

    vecs[0]  = '{1'b1, 5'h00, 32'h0000_0001, 4'hF, 2'b00, 32'h0};
    vecs[1]  = '{1'b1, 5'h04, 32'h0000_0002, 4'hF, 2'b00, 32'h0};
    vecs[2]  = '{1'b1, 5'h08, 32'h0000_0003, 4'hF, 2'b00, 32'h0};
    vecs[3]  = '{1'b1, 5'h0C, 32'h0000_0004, 4'hF, 2'b00, 32'h0};
    vecs[4]  = '{1'b0, 5'h00, 32'h0,         4'h0, 2'b00, 32'h0000_0001};
    vecs[5]  = '{1'b0, 5'h04, 32'h0,         4'h0, 2'b00, 32'h0000_0002};
    vecs[6]  = '{1'b0, 5'h08, 32'h0,         4'h0, 2'b00, 32'h0000_0003};
    vecs[7]  = '{1'b0, 5'h0C, 32'h0,         4'h0, 2'b00, 32'h0000_0004};
    vecs[8]  = '{1'b1, 5'h00, 32'h0000_0000, 4'hF, 2'b00, 32'h0};
    vecs[9]  = '{1'b1, 5'h00, 32'hAABB_CCDD, 4'h5, 2'b00, 32'h0};
    vecs[10] = '{1'b0, 5'h00, 32'h0,         4'h0, 2'b00, 32'h00BB_00DD};
    vecs[11] = '{1'b1, 5'h18, 32'hFFFF_FFFF, 4'hF, 2'b10, 32'h0};
    vecs[12] = '{1'b0, 5'h18, 32'h0,         4'h0, 2'b10, 32'h0};
    vecs[13] = '{1'b0, 5'h1C, 32'h0,         4'h0, 2'b10, 32'h0};
    vecs[14] = '{1'b1, 5'h10, 32'hFFFF_FFFF, 4'hF, 2'b00, 32'h0};
    vecs[15] = '{1'b0, 5'h10, 32'h0,         4'h0, 2'b00, 32'h1234_5678};
    vecs[16] = '{1'b1, 5'h0E, 32'h0000_AB00, 4'h2, 2'b00, 32'h0};
    vecs[17] = '{1'b0, 5'h0C, 32'h0,         4'h0, 2'b00, 32'h0000_AB04};

    rst_n = 1'b0;
    awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b0; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
    status_i = 32'h1234_5678; event_i = '0;
    repeat (3) @(negedge clk);

    chk("rst_readies", {awready, wready, arready}, 3'b111);
    chk("rst_valids", {bvalid, rvalid}, 2'b00);
    chk("rst_resps", {bresp, rresp}, 4'b0000);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_ctrl", ctrl_o, 128'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      if (vecs[i].wr) begin
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, r);
        chk($sformatf("vec%0d_bresp", i), r, vecs[i].resp);
      end else begin
        axi_read(vecs[i].addr, d, r);
        chk($sformatf("vec%0d_rresp", i), r, vecs[i].resp);
        chk($sformatf("vec%0d_rdata", i), d, vecs[i].rdata);
      end
    end
    chk("ctrl_after_table", ctrl_o, {32'h0000_AB04, 32'h3, 32'h2, 32'h00BB_00DD});

    // AW+W+AR together: write lands in cycle 1, read returns pre-write value
    @(negedge clk);
    awaddr = 5'h00; wdata = 32'h1111_1111; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 5'h00; arvalid = 1'b1; bready = 1'b0; rready = 1'b0;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("same_cyc_bvalid", bvalid, 1'b1);
    chk("same_cyc_ctrl0", ctrl_o[0], 32'h1111_1111);
    chk("same_cyc_rvalid", rvalid, 1'b1);
    chk("same_cyc_rdata_old", rdata, 32'h00BB_00DD);
    chk("same_cyc_busy", {awready, wready, arready}, 3'b000);
    bready = 1'b1; rready = 1'b1;
    @(negedge clk);
    bready = 1'b0; rready = 1'b0;
    chk("same_cyc_done", {bvalid, rvalid, awready, wready, arready}, 5'b00111);

    // W three cycles ahead of AW, then B back-pressured for five cycles
    @(negedge clk);
    wdata = 32'h0000_0099; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("w_early_%0d", k), {wready, awready, bvalid}, 3'b010);
      if (k < 2) @(negedge clk);
    end
    awaddr = 5'h08; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    chk("w_early_commit", ctrl_o[2], 32'h0000_0099);
    chk("w_early_bvalid", {bvalid, bresp}, 3'b100);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("b_hold_%0d", k), {bvalid, bresp, awready, wready}, 5'b10000);
    end
    chk("b_hold_ctrl2", ctrl_o[2], 32'h0000_0099);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    chk("b_release", {bvalid, awready, wready}, 3'b011);

    // Sticky event word: set, clear racing a new set, then a clean clear
    @(negedge clk);
    event_i = 32'h8;
    @(negedge clk);
    event_i = 32'h0;
    axi_read(5'h14, d, r);
    chk("sticky_set", d, 32'h8);
    @(negedge clk);
    awaddr = 5'h14; wdata = 32'h8; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    bready = 1'b1; event_i = 32'h8;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; event_i = 32'h0;
    chk("sticky_race_bvalid", bvalid, 1'b1);
    @(negedge clk);
    bready = 1'b0;
    axi_read(5'h14, d, r);
    chk("sticky_set_wins", d, 32'h8);
    axi_write(5'h14, 32'h8, 4'hF, r);
    chk("sticky_clr_bresp", r, 2'b00);
    axi_read(5'h14, d, r);
    chk("sticky_cleared", d, 32'h0);

    // Reset while a write response is pending
    @(negedge clk);
    awaddr = 5'h04; wdata = 32'h55; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    chk("pre_rst_bvalid", bvalid, 1'b1);
    chk("pre_rst_ctrl1", ctrl_o[1], 32'h55);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_bvalid", bvalid, 1'b0);
    chk("mid_rst_ctrl", ctrl_o, 128'h0);
    chk("mid_rst_readies", {awready, wready, arready}, 3'b111);
    @(negedge clk);
    rst_n = 1'b1;
    axi_read(5'h04, d, r);
    chk("post_rst_ctrl1_read", d, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tribuffer_axil_slave.md
Name: tribuffer_axil_slave

Overview:
AXI4-Lite responder (slave) register bank for the tribuffer IP. It sits between the PS/VIP master interface and the tribuffer datapath.
- Exposes four RW control words, one RO status word and one sticky W1C event word.
- Handles fully decoupled AW/W/B/AR/R channels, honours byte strobes, and returns SLVERR for unmapped offsets.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
C_S_AXI_ADDR_WIDTH, 5, byte address width; 8 word slots.
C_CTRL_RESET, 32'h0000_0000, reset value of control words 0-3.

Ports:
s00_axi_aclk  in  1  single clock for all logic
s00_axi_aresetn  in  1  asynchronous, active-low reset
s00_axi_awaddr  in  C_S_AXI_ADDR_WIDTH  write address
s00_axi_awprot  in  3  ignored
s00_axi_awvalid  in  1  write address valid
s00_axi_awready  out  1  write address ready
s00_axi_wdata  in  32  write data
s00_axi_wstrb  in  4  byte enables
s00_axi_wvalid  in  1  write data valid
s00_axi_wready  out  1  write data ready
s00_axi_bresp  out  2  write response
s00_axi_bvalid  out  1  write response valid
s00_axi_bready  in  1  write response ready
s00_axi_araddr  in  C_S_AXI_ADDR_WIDTH  read address
s00_axi_arprot  in  3  ignored
s00_axi_arvalid  in  1  read address valid
s00_axi_arready  out  1  read address ready
s00_axi_rdata  out  32  read data
s00_axi_rresp  out  2  read response
s00_axi_rvalid  out  1  read valid
s00_axi_rready  in  1  read ready
ctrl_o  out  4x32  control words 0-3 (offsets 0x00-0x0C)
status_i  in  32  live status, readable at 0x10
event_i  in  32  per-bit event pulses, sticky at 0x14

Behaviour:
Reset:
- awready, wready, arready = 1.
- bvalid, rvalid = 0; bresp, rresp = 0; rdata = 0.
- ctrl_o = C_CTRL_RESET; sticky word = 0.
- Reset asserted mid-transaction discards all latched addr/data and any pending response; no partial write is applied.

Write path:
- States: W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP.
- AW and W are accepted independently and each is latched. awready drops after an AW handshake, wready after a W handshake.
- When both are held, the write commits on the next edge, bvalid rises in that same cycle, and state becomes W_RESP.
- AW and W handshaked in the same cycle (cycle 0): register updated and bvalid=1 in cycle 1.
- bvalid holds with stable bresp until bready. Then awready=wready=1 and state returns to W_IDLE.
- No new AW or W is accepted while in W_RESP.

Write decode, on word index awaddr[4:2]:
- 0-3: per-byte update where wstrb[b]=1; OKAY.
- 4: write ignored; OKAY.
- 5: write-1-to-clear, strobe-qualified; OKAY.
- 6-7: no state change; SLVERR (2'b10).
- awaddr[1:0] is ignored.

Sticky word:
- Each cycle: sticky <= (sticky & ~clr_mask) | event_i.
- A set in the same cycle as a clear wins (bit stays 1).

Read path:
- States: R_IDLE, R_RESP.
- AR handshake in cycle 0 gives rvalid=1 in cycle 1, with rdata captured at the cycle-0 edge.
- arready=0 while rvalid=1. rdata and rresp stay stable until rready.
- Read decode: 0-3 return ctrl words, 4 returns status_i (sampled), 5 returns the sticky word. Indices 6-7 return rdata=0 with SLVERR.
- Read and write to the same word in the same cycle: the read returns the pre-write value.

Decomposition:
- Package tribuffer_axil_pkg holds:
  - word-index localparams REG_CTRL0..3, REG_STATUS, REG_EVENT;
  - RESP_OKAY and RESP_SLVERR;
  - write/read state enums;
  - function apply_wstrb(old, data, strb).
- A single module is natural; no sub-module is required.

Test Plan:
- Write 1,2,3,4 to 0x0,0x4,0x8,0xC, then read back -> rdata 1,2,3,4, every bresp/rresp OKAY.
- Write 0xAABBCCDD to 0x0 with wstrb=4'b0101 over a previous value of 0 -> read 0x00BB00DD.
- W presented 3 cycles before AW, bready held low for 5 cycles -> single commit, bvalid held 5+ cycles, awready/wready=0 throughout.
- Write and read at 0x18 -> bresp=2'b10, rresp=2'b10, rdata=0, ctrl_o unchanged.
- Pulse event_i bit 3 -> read 0x14 gives 0x8. Write 0x8 to 0x14 while event_i bit 3 pulses again -> bit stays set. Clear again -> reads 0.
- Assert aresetn=0 while bvalid=1 after a write of 0x55 to 0x4 -> bvalid=0 immediately, and ctrl_o[1] returns to C_CTRL_RESET.
